// File: rtl/can_fifo_pkg.sv
// Shared constants and helpers for the CAN message FIFO.
package can_fifo_pkg;

    localparam int CAN_FRAME_WIDTH        = 128;
    localparam int CAN_FIFO_DEFAULT_DEPTH = 8;

    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/can_msg_fifo_if.sv
// Host-side port bundle of the CAN message FIFO.
interface can_msg_fifo_if
    import can_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CAN_FRAME_WIDTH,
    parameter int DEPTH      = CAN_FIFO_DEFAULT_DEPTH
);

    logic                         i_wr_en;
    logic [DATA_WIDTH-1:0]        i_wr_data;
    logic                         i_rd_en;
    logic                         i_clr_err;
    logic [DATA_WIDTH-1:0]        o_rd_data;
    logic                         o_rd_valid;
    logic                         o_full;
    logic                         o_empty;
    logic                         o_almost_full;
    logic                         o_almost_empty;
    logic [fifo_cw(DEPTH)-1:0]    o_count;
    logic                         o_overflow;
    logic                         o_underflow;

    modport master (
        output i_wr_en, i_wr_data, i_rd_en, i_clr_err,
        input  o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_rd_en, i_clr_err,
        output o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_overflow, o_underflow
    );

endinterface

// File: rtl/can_fifo_ram.sv
// Unreset storage array: one synchronous write port, one asynchronous read port.
module can_fifo_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8,
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  i_sys_clk,
    input  logic                  wr_en,
    input  logic [PW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/can_msg_fifo.sv
// Parametrised CAN frame FIFO: pointers, occupancy, threshold flags, sticky errors,
// and a registered or first-word-fall-through read port.
module can_msg_fifo
    import can_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CAN_FRAME_WIDTH,
    parameter int DEPTH      = CAN_FIFO_DEFAULT_DEPTH,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic           i_sys_clk,
    input  logic           i_reset,
    can_msg_fifo_if.slave  bus
);

    localparam int CW = fifo_cw(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         w_ptr, r_ptr;
    logic [CW-1:0]         count_q, count_nxt;
    logic                  full_q, empty_q, afull_q, aempty_q;
    logic                  ovf_q, unf_q;
    logic                  rd_ok, wr_ok;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Wrap at DEPTH-1 rather than relying on binary rollover.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rd_ok     = bus.i_rd_en & ~empty_q;
    assign wr_ok     = bus.i_wr_en & (~full_q | rd_ok);
    assign count_nxt = count_q + CW'(wr_ok) - CW'(rd_ok);

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_ok) w_ptr <= ptr_inc(w_ptr);
            if (rd_ok) r_ptr <= ptr_inc(r_ptr);
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CW'(DEPTH));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= CW'(AF_LEVEL));
            aempty_q <= (count_nxt <= CW'(AE_LEVEL));
            // A new error in the clearing cycle keeps the flag set.
            ovf_q    <= (bus.i_wr_en & ~wr_ok) | (ovf_q & ~bus.i_clr_err);
            unf_q    <= (bus.i_rd_en & ~rd_ok) | (unf_q & ~bus.i_clr_err);
        end
    end

    can_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_sys_clk (i_sys_clk),
        .wr_en     (wr_ok),
        .wr_addr   (w_ptr),
        .wr_data   (bus.i_wr_data),
        .rd_addr   (r_ptr),
        .rd_data   (ram_rd_data)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.o_rd_data  = ram_rd_data;
            assign bus.o_rd_valid = ~empty_q;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge i_sys_clk) begin
                if (i_reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) rd_data_q <= ram_rd_data;
                end
            end

            assign bus.o_rd_data  = rd_data_q;
            assign bus.o_rd_valid = rd_valid_q;
        end
    endgenerate

    assign bus.o_count        = count_q;
    assign bus.o_full         = full_q;
    assign bus.o_empty        = empty_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_almost_empty = aempty_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_underflow    = unf_q;

endmodule
